// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for the game-board RAM arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface ram_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ready;
    logic [DW-1:0] disp_rdata;
    logic          kb_req;
    logic [AW-1:0] kb_addr;
    logic [DW-1:0] kb_wdata;
    logic          kb_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;
    logic [1:0]    gnt_id;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  disp_req, disp_addr,
        input  kb_req, kb_addr, kb_wdata,
        input  ram_dout,
        output cpu_ready, cpu_rdata,
        output disp_ready, disp_rdata,
        output kb_ack,
        output ram_addr, ram_we, ram_din,
        output busy, gnt_id
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output disp_req, disp_addr,
        output kb_req, kb_addr, kb_wdata,
        output ram_dout,
        input  cpu_ready, cpu_rdata,
        input  disp_ready, disp_rdata,
        input  kb_ack,
        input  ram_addr, ram_we, ram_din,
        input  busy, gnt_id
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: CPU > DISP > KB with per-port starvation override.
// One access in flight; IDLE -> ISSUE -> WAIT (reads) -> DONE.
module ram_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] W_LAST = LW'(RD_LAT - 1);
    localparam logic [CW-1:0] S_MAX  = CW'(STARVE_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_CPU  = 2'd1;
    localparam logic [1:0] G_DISP = 2'd2;
    localparam logic [1:0] G_KB   = 2'd3;

    logic [1:0]          state;
    logic [1:0]          gnt;
    logic                lat_we;
    logic [LW-1:0]       wcnt;
    logic [2:0][CW-1:0]  cnt;
    logic [AW-1:0]       addr_q;
    logic                we_q;
    logic [DW-1:0]       din_q;
    logic [DW-1:0]       cpu_rdata_q;
    logic [DW-1:0]       disp_rdata_q;
    logic                cpu_ready_q;
    logic                disp_ready_q;
    logic                kb_ack_q;

    logic [2:0]    req;
    logic [2:0]    starved;
    logic [2:0]    pool;
    logic [1:0]    win;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_we;

    // Starved ports form the candidate pool when any exist.
    always_comb begin
        req     = {bus.kb_req, bus.disp_req, bus.cpu_req};
        starved = {req[2] && (cnt[2] == S_MAX),
                   req[1] && (cnt[1] == S_MAX),
                   req[0] && (cnt[0] == S_MAX)};
        pool    = (|starved) ? starved : req;
    end

    always_comb begin
        win       = G_NONE;
        win_addr  = bus.cpu_addr;
        win_wdata = bus.cpu_wdata;
        win_we    = bus.cpu_we;
        priority case (1'b1)
            pool[0]: win = G_CPU;
            pool[1]: begin
                win      = G_DISP;
                win_addr = bus.disp_addr;
                win_we   = 1'b0;
            end
            pool[2]: begin
                win       = G_KB;
                win_addr  = bus.kb_addr;
                win_wdata = bus.kb_wdata;
                win_we    = 1'b1;
            end
            default: win = G_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            gnt          <= G_NONE;
            lat_we       <= 1'b0;
            wcnt         <= '0;
            cnt          <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            din_q        <= '0;
            cpu_rdata_q  <= '0;
            disp_rdata_q <= '0;
            cpu_ready_q  <= 1'b0;
            disp_ready_q <= 1'b0;
            kb_ack_q     <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            cpu_ready_q  <= 1'b0;
            disp_ready_q <= 1'b0;
            kb_ack_q     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    for (int i = 0; i < 3; i++) begin
                        if (win == 2'(i + 1))
                            cnt[i] <= '0;
                        else if (req[i])
                            cnt[i] <= (cnt[i] == S_MAX) ? S_MAX
                                                        : cnt[i] + 1'b1;
                        else
                            cnt[i] <= '0;
                    end
                    if (win != G_NONE) begin
                        gnt    <= win;
                        addr_q <= win_addr;
                        lat_we <= win_we;
                        we_q   <= win_we;
                        if (win_we)
                            din_q <= win_wdata;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wcnt <= '0;
                    if (lat_we) begin
                        cpu_ready_q <= (gnt == G_CPU);
                        kb_ack_q    <= (gnt == G_KB);
                        state       <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == W_LAST) begin
                        if (gnt == G_CPU) begin
                            cpu_rdata_q <= bus.ram_dout;
                            cpu_ready_q <= 1'b1;
                        end
                        if (gnt == G_DISP) begin
                            disp_rdata_q <= bus.ram_dout;
                            disp_ready_q <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_addr   = addr_q;
    assign bus.ram_we     = we_q;
    assign bus.ram_din    = din_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.disp_ready = disp_ready_q;
    assign bus.disp_rdata = disp_rdata_q;
    assign bus.kb_ack     = kb_ack_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.gnt_id     = gnt;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter (RD_LAT=1, STARVE_MAX=2).
// Completion pulses are queued by step() and matched against expectations.
module tb_ram_port_arbiter;
    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        bit          chk;
        int          cyc;
        logic [1:0]  gnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    bit   keep_cpu = 1'b0;
    bit   keep_disp = 1'b0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] mem [0:1023];

    ram_port_arbiter_if #(.AW(10), .DW(32)) bus();

    ram_port_arbiter #(
        .AW(10), .DW(32), .RD_LAT(1), .STARVE_MAX(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model, one cycle read latency.
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_addr] <= pre_data;
        else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        if (bus.cpu_ready)
            obs_q.push_back(ev_t'{2'd1, bus.cpu_rdata, 1'b0, cyc, bus.gnt_id});
        if (bus.disp_ready)
            obs_q.push_back(ev_t'{2'd2, bus.disp_rdata, 1'b0, cyc, bus.gnt_id});
        if (bus.kb_ack)
            obs_q.push_back(ev_t'{2'd3, 32'd0, 1'b0, cyc, bus.gnt_id});
        if (bus.cpu_ready && !keep_cpu) bus.cpu_req = 1'b0;
        if (bus.disp_ready && !keep_disp) bus.disp_req = 1'b0;
        if (bus.kb_ack) bus.kb_req = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int k = 0; k < budget && obs_q.size() < n; k++) step();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bus.busy; k++) step();
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en = 1'b1;
        step();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_req = 1'b1;
        bus.disp_req = 1'b1;
        bus.kb_req = 1'b1;
        step();
        step();
        ncmp++;
        if ({bus.cpu_ready, bus.disp_ready, bus.kb_ack} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_pulses: got %b want 000",
                     {bus.cpu_ready, bus.disp_ready, bus.kb_ack});
        end
        ncmp++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 10'd0) begin
            nerr++;
            $display("FAIL reset_ram: we=%b addr=%h want 0/000",
                     bus.ram_we, bus.ram_addr);
        end
        ncmp++;
        if (bus.busy !== 1'b0 || bus.gnt_id !== 2'b00) begin
            nerr++;
            $display("FAIL reset_state: busy=%b gnt=%b want 0/00",
                     bus.busy, bus.gnt_id);
        end
        ncmp++;
        if (bus.cpu_rdata !== 32'd0 || bus.disp_rdata !== 32'd0
            || bus.ram_din !== 32'd0) begin
            nerr++;
            $display("FAIL reset_data: cpu=%h disp=%h din=%h want 0",
                     bus.cpu_rdata, bus.disp_rdata, bus.ram_din);
        end
        bus.cpu_req = 1'b0;
        bus.disp_req = 1'b0;
        bus.kb_req = 1'b0;
        rst = 1'b0;
        step();
        ncmp++;
        if (obs_q.size() != 0) begin
            nerr++;
            $display("FAIL reset_no_pulse: got %0d pulses want 0",
                     obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_cpu_write();
        ev_t e;
        ev_t o;
        int  n;
        wait_idle();
        n = cyc;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 10'h005;
        bus.cpu_wdata = 32'hDEADBEEF;
        exp_q.push_back(ev_t'{2'd1, 32'd0, 1'b0, n + 2, 2'd0});
        step();
        ncmp++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'h005
            || bus.ram_din !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL wr_issue: we=%b addr=%h din=%h want 1/005/deadbeef",
                     bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        step();
        ncmp++;
        if (bus.ram_we !== 1'b0) begin
            nerr++;
            $display("FAIL wr_one_cycle: we=%b want 0", bus.ram_we);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncmp++;
            if (obs_q.size() == 0) begin
                nerr++;
                $display("FAIL cpu_write: no pulse, want id=%0d cyc=%0d",
                         e.id, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.cyc !== e.cyc || o.gnt !== e.id) begin
                    nerr++;
                    $display("FAIL cpu_write: got id=%0d gnt=%0d cyc=%0d want id=%0d cyc=%0d",
                             o.id, o.gnt, o.cyc, e.id, e.cyc);
                end
            end
        end
        ncmp++;
        if (mem[5] !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL wr_mem: got %h want deadbeef", mem[5]);
        end
    endtask

    task automatic test_disp_read();
        ev_t e;
        ev_t o;
        int  n;
        preload(10'h010, 32'h00000800);
        wait_idle();
        n = cyc;
        bus.disp_req = 1'b1;
        bus.disp_addr = 10'h010;
        exp_q.push_back(ev_t'{2'd2, 32'h00000800, 1'b1, n + 3, 2'd0});
        wait_obs(1, 20);
        wait_idle();
        n = cyc;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'h005;
        exp_q.push_back(ev_t'{2'd1, 32'hDEADBEEF, 1'b1, n + 3, 2'd0});
        wait_obs(2, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncmp++;
            if (obs_q.size() == 0) begin
                nerr++;
                $display("FAIL rd_pulse: none, want id=%0d cyc=%0d",
                         e.id, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.cyc !== e.cyc || o.gnt !== e.id
                    || (e.chk && o.data !== e.data)) begin
                    nerr++;
                    $display("FAIL rd_pulse: got id=%0d gnt=%0d cyc=%0d data=%h want id=%0d cyc=%0d data=%h",
                             o.id, o.gnt, o.cyc, o.data, e.id, e.cyc, e.data);
                end
            end
        end
        ncmp++;
        if (bus.disp_rdata !== 32'h00000800) begin
            nerr++;
            $display("FAIL disp_hold: got %h want 00000800", bus.disp_rdata);
        end
    endtask

    task automatic test_simultaneous();
        ev_t e;
        ev_t o;
        int  n;
        preload(10'h001, 32'h11111111);
        preload(10'h002, 32'h22222222);
        wait_idle();
        n = cyc;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'h001;
        bus.disp_req = 1'b1;
        bus.disp_addr = 10'h002;
        bus.kb_req = 1'b1;
        bus.kb_addr = 10'h003;
        bus.kb_wdata = 32'h0000001C;
        exp_q.push_back(ev_t'{2'd1, 32'h11111111, 1'b1, n + 3, 2'd0});
        exp_q.push_back(ev_t'{2'd2, 32'h22222222, 1'b1, n + 7, 2'd0});
        exp_q.push_back(ev_t'{2'd3, 32'd0, 1'b0, n + 10, 2'd0});
        wait_obs(3, 40);
        for (int k = 0; k < 4; k++) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncmp++;
            if (obs_q.size() == 0) begin
                nerr++;
                $display("FAIL simul: no pulse, want id=%0d cyc=%0d",
                         e.id, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.cyc !== e.cyc || o.gnt !== e.id
                    || (e.chk && o.data !== e.data)) begin
                    nerr++;
                    $display("FAIL simul: got id=%0d gnt=%0d cyc=%0d data=%h want id=%0d cyc=%0d data=%h",
                             o.id, o.gnt, o.cyc, o.data, e.id, e.cyc, e.data);
                end
            end
        end
        ncmp++;
        if (obs_q.size() != 0) begin
            nerr++;
            $display("FAIL simul_extra: got %0d extra pulses want 0",
                     obs_q.size());
            obs_q.delete();
        end
        ncmp++;
        if (mem[3] !== 32'h0000001C) begin
            nerr++;
            $display("FAIL kb_mem: got %h want 0000001c", mem[3]);
        end
    endtask

    task automatic test_starvation();
        ev_t e;
        ev_t o;
        int  n;
        wait_idle();
        n = cyc;
        keep_cpu = 1'b1;
        keep_disp = 1'b1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 10'h020;
        bus.cpu_wdata = 32'h00000055;
        bus.disp_req = 1'b1;
        bus.disp_addr = 10'h010;
        exp_q.push_back(ev_t'{2'd1, 32'd0, 1'b0, n + 2, 2'd0});
        exp_q.push_back(ev_t'{2'd1, 32'd0, 1'b0, n + 5, 2'd0});
        exp_q.push_back(ev_t'{2'd2, 32'h00000800, 1'b1, n + 9, 2'd0});
        exp_q.push_back(ev_t'{2'd1, 32'd0, 1'b0, n + 12, 2'd0});
        exp_q.push_back(ev_t'{2'd1, 32'd0, 1'b0, n + 15, 2'd0});
        exp_q.push_back(ev_t'{2'd2, 32'h00000800, 1'b1, n + 19, 2'd0});
        wait_obs(6, 60);
        keep_cpu = 1'b0;
        keep_disp = 1'b0;
        bus.cpu_req = 1'b0;
        bus.disp_req = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncmp++;
            if (obs_q.size() == 0) begin
                nerr++;
                $display("FAIL starve: no pulse, want id=%0d cyc=%0d",
                         e.id, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.cyc !== e.cyc || o.gnt !== e.id
                    || (e.chk && o.data !== e.data)) begin
                    nerr++;
                    $display("FAIL starve: got id=%0d gnt=%0d cyc=%0d data=%h want id=%0d cyc=%0d data=%h",
                             o.id, o.gnt, o.cyc, o.data, e.id, e.cyc, e.data);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        ev_t e;
        ev_t o;
        int  n;
        wait_idle();
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 10'h001;
        step();
        step();
        ncmp++;
        if (bus.busy !== 1'b1 || bus.ram_addr !== 10'h001) begin
            nerr++;
            $display("FAIL mid_wait: busy=%b addr=%h want 1/001",
                     bus.busy, bus.ram_addr);
        end
        rst = 1'b1;
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            rst = 1'b0;
            ncmp++;
            if (bus.ram_we !== 1'b0 || bus.cpu_ready !== 1'b0) begin
                nerr++;
                $display("FAIL mid_abort: we=%b ready=%b want 0/0",
                         bus.ram_we, bus.cpu_ready);
            end
        end
        ncmp++;
        if (bus.busy !== 1'b0 || bus.gnt_id !== 2'b00
            || obs_q.size() != 0) begin
            nerr++;
            $display("FAIL mid_state: busy=%b gnt=%b pulses=%0d want 0/00/0",
                     bus.busy, bus.gnt_id, obs_q.size());
            obs_q.delete();
        end
        n = cyc;
        bus.kb_req = 1'b1;
        bus.kb_addr = 10'h030;
        bus.kb_wdata = 32'h000000A5;
        exp_q.push_back(ev_t'{2'd3, 32'd0, 1'b0, n + 2, 2'd0});
        wait_obs(1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ncmp++;
            if (obs_q.size() == 0) begin
                nerr++;
                $display("FAIL kb_after_rst: no pulse, want cyc=%0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.id !== e.id || o.cyc !== e.cyc || o.gnt !== e.id) begin
                    nerr++;
                    $display("FAIL kb_after_rst: got id=%0d gnt=%0d cyc=%0d want id=%0d cyc=%0d",
                             o.id, o.gnt, o.cyc, e.id, e.cyc);
                end
            end
        end
        step();
        ncmp++;
        if (mem[10'h030] !== 32'h000000A5) begin
            nerr++;
            $display("FAIL kb_after_rst_mem: got %h want 000000a5",
                     mem[10'h030]);
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.disp_req = 1'b0;
        bus.disp_addr = '0;
        bus.kb_req = 1'b0;
        bus.kb_addr = '0;
        bus.kb_wdata = '0;
        test_reset();
        test_cpu_write();
        test_disp_read();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
